ir400_pulse_ctrl: RTL and testbench

Digital pulse sequencer that generates the 8-bit ng_en leg-enable bus for the IR400 constant-current sink driver.
- Each ng_en bit enables three equal sink legs, so sink current is proportional to popcount(ng_en).
- The block emits a programmable train of IR pulses, each a soft ramp-up, a flat top, a soft ramp-down, and an off gap, with a start/busy/done handshake toward the SoC register block.
- Ramping limits di/dt on the LED supply rail.

---
 rtl/ir400_pkg.sv | 29 ++
 rtl/ir400_dn_timer.sv | 27 ++
 rtl/ir400_pulse_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ir400_pulse_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir400_pkg.sv
// Shared types and helpers for the IR400 pulse sequencer.
package ir400_pkg;

    localparam int LVL_MAX = 8;
    localparam int NG_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN,
        ST_OFF
    } state_e;

    // Bits [lvl-1:0] set; lvl >= NG_W saturates to all ones.
    function automatic logic [NG_W-1:0] therm8(input logic [3:0] lvl);
        logic [NG_W-1:0] t;
        t = '0;
        for (int i = 0; i < NG_W; i++) begin
            t[i] = (4'(i) < lvl);
        end
        return t;
    endfunction

    function automatic logic [3:0] clamp_lvl(input logic [3:0] lvl);
        return (lvl > 4'(LVL_MAX)) ? 4'(LVL_MAX) : lvl;
    endfunction

endpackage

// File: rtl/ir400_dn_timer.sv
// Loadable down-counter with a zero flag; times both the flat top and the off gap.
module ir400_dn_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ir400_pulse_ctrl.sv
// IR400 pulse sequencer: ramped pulse trains on the thermometer leg-enable bus
// of the constant-current sink, with a start/busy/done handshake.
module ir400_pulse_ctrl
    import ir400_pkg::*;
#(
    parameter int              RAMP_DIV = 4,
    parameter int              ON_W     = 16,
    parameter int              CNT_W    = 8,
    parameter logic [ON_W-1:0] MAX_ON   = ON_W'(50000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       level,
    input  logic [ON_W-1:0]  on_cycles,
    input  logic [ON_W-1:0]  off_cycles,
    input  logic [CNT_W-1:0] pulse_count,
    output logic [NG_W-1:0]  ng_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             pulse_active
);

    localparam int              RC_W    = $clog2(RAMP_DIV) + 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);

    state_e           state_q, state_d;
    logic [3:0]       lvl_q, lvl_d, cur_q, cur_d;
    logic [ON_W-1:0]  on_q, on_d, off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, pdone_q, pdone_d;
    logic [RC_W-1:0]  ramp_q, ramp_d;
    logic             abrt_q, abrt_d;
    logic             busy_q, done_q, done_d, aborted_q, aborted_d, pa_q;
    logic [NG_W-1:0]  ng_q;

    logic             tmr_load, tmr_en, tmr_zero;
    logic [ON_W-1:0]  tmr_val;
    logic [3:0]       lvl_in;
    logic [ON_W-1:0]  on_in;
    logic             step, ramp_end;

    assign lvl_in   = clamp_lvl(level);
    assign on_in    = (on_cycles == '0)    ? ON_W'(1) :
                      (on_cycles > MAX_ON) ? MAX_ON   : on_cycles;
    assign step     = (ramp_q == RC_LAST);
    // cur_q==0 in RAMP_DOWN only happens after an abort taken before the first step.
    assign ramp_end = (cur_q == 4'd0) || ((cur_q == 4'd1) && step);

    ir400_dn_timer #(.W(ON_W)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        cur_d     = cur_q;
        on_d      = on_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        pdone_d   = pdone_q;
        ramp_d    = ramp_q;
        abrt_d    = abrt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((lvl_in == 4'd0) || (pulse_count == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP_UP;
                        lvl_d   = lvl_in;
                        on_d    = on_in;
                        off_d   = off_cycles;
                        cnt_d   = pulse_count;
                        cur_d   = 4'd0;
                        ramp_d  = '0;
                        pdone_d = '0;
                        abrt_d  = 1'b0;
                    end
                end
            end

            ST_RAMP_UP: begin
                if (abort) begin
                    state_d = ST_RAMP_DOWN;
                    ramp_d  = '0;
                    abrt_d  = 1'b1;
                end else if (step) begin
                    ramp_d = '0;
                    cur_d  = cur_q + 4'd1;
                    if ((cur_q + 4'd1) == lvl_q) begin
                        state_d  = ST_ON;
                        tmr_load = 1'b1;
                        tmr_val  = on_q - 1'b1;
                    end
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end

            ST_ON: begin
                if (abort) begin
                    state_d = ST_RAMP_DOWN;
                    ramp_d  = '0;
                    abrt_d  = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ST_RAMP_DOWN;
                    ramp_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_RAMP_DOWN: begin
                if (abort) begin
                    abrt_d = 1'b1;
                end
                if (ramp_end) begin
                    cur_d   = 4'd0;
                    ramp_d  = '0;
                    pdone_d = pdone_q + 1'b1;
                    if (abrt_q || abort) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        aborted_d = 1'b1;
                    end else if (pdone_d == cnt_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (off_q != '0) begin
                        state_d  = ST_OFF;
                        tmr_load = 1'b1;
                        tmr_val  = off_q - 1'b1;
                    end else begin
                        state_d = ST_RAMP_UP;
                    end
                end else if (step) begin
                    ramp_d = '0;
                    cur_d  = cur_q - 4'd1;
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end

            ST_OFF: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ST_RAMP_UP;
                    ramp_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lvl_q     <= '0;
            cur_q     <= '0;
            on_q      <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            pdone_q   <= '0;
            ramp_q    <= '0;
            abrt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            pa_q      <= 1'b0;
            ng_q      <= '0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            cur_q     <= cur_d;
            on_q      <= on_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            pdone_q   <= pdone_d;
            ramp_q    <= ramp_d;
            abrt_q    <= abrt_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
            // Driver-facing bits come straight from flops so the legs never see decode glitches.
            pa_q      <= (cur_d != 4'd0);
            ng_q      <= therm8(cur_d);
        end
    end

    assign ng_en        = ng_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign pulse_active = pa_q;

endmodule

// File: tb/tb_ir400_pulse_ctrl.sv
// Directed bench for ir400_pulse_ctrl: three instances cover RAMP_DIV 2/4/1 and MAX_ON clamping.
module tb_ir400_pulse_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic        abort;
    logic [3:0]  level;
    logic [15:0] on_c, off_c;
    logic [7:0]  pcnt;

    logic [7:0]  ng_v   [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic        ab_v   [3];
    logic        pa_v   [3];

    int checks = 0;
    int fails  = 0;
    int tr[$];
    int ex[$];
    int nbusy, ndone, lastab, didx, npa;

    always #5 clk = ~clk;

    ir400_pulse_ctrl #(.RAMP_DIV(2), .ON_W(16), .CNT_W(8), .MAX_ON(16'd100)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .level(level),
        .on_cycles(on_c), .off_cycles(off_c), .pulse_count(pcnt),
        .ng_en(ng_v[0]), .busy(busy_v[0]), .done(done_v[0]), .aborted(ab_v[0]),
        .pulse_active(pa_v[0]));

    ir400_pulse_ctrl #(.RAMP_DIV(4), .ON_W(16), .CNT_W(8), .MAX_ON(16'd50000)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .level(level),
        .on_cycles(on_c), .off_cycles(off_c), .pulse_count(pcnt),
        .ng_en(ng_v[1]), .busy(busy_v[1]), .done(done_v[1]), .aborted(ab_v[1]),
        .pulse_active(pa_v[1]));

    ir400_pulse_ctrl #(.RAMP_DIV(1), .ON_W(16), .CNT_W(8), .MAX_ON(16'd100)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .level(level),
        .on_cycles(on_c), .off_cycles(off_c), .pulse_count(pcnt),
        .ng_en(ng_v[2]), .busy(busy_v[2]), .done(done_v[2]), .aborted(ab_v[2]),
        .pulse_active(pa_v[2]));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int th(input int l);
        return (1 << l) - 1;
    endfunction

    // Expected ng_en per cycle after the start edge, ending with the done cycle.
    task automatic build(input int lvl, input int div, input int on, input int off, input int cnt);
        ex.delete();
        for (int p = 0; p < cnt; p++) begin
            for (int l = 0; l < lvl; l++) repeat (div) ex.push_back(th(l));
            repeat (on) ex.push_back(th(lvl));
            for (int l = lvl; l > 0; l--) repeat (div) ex.push_back(th(l));
            if (p != cnt - 1) repeat (off) ex.push_back(0);
        end
        ex.push_back(0);
    endtask

    // Entered at a negedge; tr[k] holds ng_en sampled after edge k (edge 0 takes start).
    task automatic run(input string tag, input int d, input int maxc, input int ab_at, input int st_at);
        int extra;
        tr.delete();
        nbusy = 0; ndone = 0; lastab = 0; didx = -1; npa = 0; extra = 0;
        for (int k = 0; k < maxc && didx < 0; k++) begin
            start_v    = '0;
            start_v[d] = (k == 0) || (k == st_at);
            abort      = (k == ab_at);
            if (k == st_at) begin
                level = 4'd8;
                on_c  = 16'd1;
            end
            @(posedge clk);
            @(negedge clk);
            start_v = '0;
            abort   = 1'b0;
            tr.push_back(int'(ng_v[d]));
            if (busy_v[d]) nbusy++;
            if (int'(pa_v[d]) != int'(ng_v[d] != 8'd0)) npa++;
            if (done_v[d]) begin
                ndone++;
                lastab = int'(ab_v[d]);
                didx   = k;
            end
        end
        chk({tag, "_done_seen"}, int'(didx >= 0), 1);
        chk({tag, "_pa_vs_ng"}, npa, 0);
        repeat (3) begin
            @(negedge clk);
            if (done_v[d] || busy_v[d]) extra++;
        end
        chk({tag, "_quiet_after"}, extra, 0);
    endtask

    task automatic cmp_seq(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < ex.size() && i < tr.size(); i++)
            if (bad < 0 && tr[i] != ex[i]) bad = i;
        chk({tag, "_len"}, tr.size(), ex.size());
        chk({tag, "_first_bad_idx"}, bad, -1);
    endtask

    function automatic int count_val(input int v);
        int n;
        n = 0;
        foreach (tr[i]) if (tr[i] == v) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b1; start_v = '0; abort = 1'b0;
        level = '0; on_c = '0; off_c = '0; pcnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_ng_a",   int'(ng_v[0]),   0);
        chk("rst_busy_a", int'(busy_v[0]), 0);
        chk("rst_done_a", int'(done_v[0]), 0);
        chk("rst_ab_a",   int'(ab_v[0]),   0);
        chk("rst_pa_a",   int'(pa_v[0]),   0);
        chk("rst_ng_b",   int'(ng_v[1]),   0);
        rst = 1'b0;
        @(negedge clk);

        // Basic two-pulse train
        level = 4'd3; on_c = 16'd5; off_c = 16'd4; pcnt = 8'd2;
        run("basic", 0, 100, -1, -1);
        build(3, 2, 5, 4, 2);
        cmp_seq("basic");
        chk("basic_busy_cycles", nbusy, 38);
        chk("basic_done_idx", didx, 38);
        chk("basic_ndone", ndone, 1);
        chk("basic_aborted", lastab, 0);
        chk("basic_tr2", tr[2], 8'h01);
        chk("basic_tr4", tr[4], 8'h03);
        chk("basic_tr6", tr[6], 8'h07);
        chk("basic_tr17", tr[17], 8'h00);

        // Level clamp and on=0 -> one flat-top cycle at 0xFF
        level = 4'd12; on_c = 16'd0; off_c = 16'd0; pcnt = 8'd1;
        run("clamp_lvl", 0, 100, -1, -1);
        build(8, 2, 1, 0, 1);
        cmp_seq("clamp_lvl");
        chk("clamp_lvl_ff_cycles", count_val(255), 3);

        // on=65535 clamps to MAX_ON=100
        level = 4'd1; on_c = 16'hFFFF; off_c = 16'd0; pcnt = 8'd1;
        run("clamp_on", 0, 300, -1, -1);
        build(1, 2, 100, 0, 1);
        cmp_seq("clamp_on");
        chk("clamp_on_level1_cycles", count_val(1), 102);

        // Zero level / zero count
        level = 4'd0; on_c = 16'd3; off_c = 16'd0; pcnt = 8'd5;
        run("zero_lvl", 0, 10, -1, -1);
        chk("zero_lvl_done_idx", didx, 0);
        chk("zero_lvl_busy", nbusy, 0);
        chk("zero_lvl_ng", tr[0], 0);
        level = 4'd3; pcnt = 8'd0;
        run("zero_cnt", 0, 10, -1, -1);
        chk("zero_cnt_done_idx", didx, 0);
        chk("zero_cnt_busy", nbusy, 0);

        // off=0, three pulses, RAMP_DIV=1: single 0x00 cycle between pulses
        level = 4'd2; on_c = 16'd2; off_c = 16'd0; pcnt = 8'd3;
        run("off0", 2, 60, -1, -1);
        build(2, 1, 2, 0, 3);
        cmp_seq("off0");
        chk("off0_tr5", tr[5], 8'h01);
        chk("off0_tr6", tr[6], 8'h00);
        chk("off0_tr7", tr[7], 8'h01);

        // Abort during ON at level 8, RAMP_DIV=4
        level = 4'd8; on_c = 16'd100; off_c = 16'd0; pcnt = 8'd1;
        run("abort_on", 1, 300, 40, -1);
        chk("abort_on_tr39", tr[39], 8'hFF);
        chk("abort_on_tr43", tr[43], 8'hFF);
        chk("abort_on_tr44", tr[44], 8'h7F);
        chk("abort_on_tr71", tr[71], 8'h01);
        chk("abort_on_done_idx", didx, 72);
        chk("abort_on_aborted", lastab, 1);
        chk("abort_on_ndone", ndone, 1);

        // Abort during OFF
        level = 4'd1; on_c = 16'd1; off_c = 16'd10; pcnt = 8'd3;
        run("abort_off", 0, 60, 7, -1);
        chk("abort_off_tr2", tr[2], 8'h01);
        chk("abort_off_tr5", tr[5], 8'h00);
        chk("abort_off_tr7", tr[7], 8'h00);
        chk("abort_off_done_idx", didx, 7);
        chk("abort_off_aborted", lastab, 1);

        // start together with abort in IDLE is ignored
        start_v[0] = 1'b1; abort = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v = '0; abort = 1'b0;
        chk("startabort_busy", int'(busy_v[0]), 0);
        chk("startabort_done", int'(done_v[0]), 0);
        @(negedge clk);
        chk("startabort_busy2", int'(busy_v[0]), 0);

        // Synchronous reset in ON at level 5, then restart right after
        level = 4'd5; on_c = 16'd20; off_c = 16'd0; pcnt = 8'd1;
        start_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v = '0;
        repeat (11) @(negedge clk);
        chk("rstmid_pre_ng", int'(ng_v[0]), 8'h1F);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ng", int'(ng_v[0]), 0);
        chk("rstmid_busy", int'(busy_v[0]), 0);
        chk("rstmid_pa", int'(pa_v[0]), 0);
        rst = 1'b0;
        level = 4'd2; on_c = 16'd1; off_c = 16'd0; pcnt = 8'd1;
        run("after_rst", 0, 50, -1, -1);
        build(2, 2, 1, 0, 1);
        cmp_seq("after_rst");

        // Second start plus level change while busy have no effect
        level = 4'd3; on_c = 16'd5; off_c = 16'd4; pcnt = 8'd2;
        run("restart", 0, 100, -1, 10);
        build(3, 2, 5, 4, 2);
        cmp_seq("restart");
        chk("restart_busy_cycles", nbusy, 38);
        chk("restart_ndone", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
